// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin shared-bus arbiter with optional master-0 priority,
// tristate turnaround gap and a BUS_ready watchdog that revokes hung owners.
module bus_arbiter #(
    parameter int NREQ        = 2,
    parameter int IDW         = 1,
    parameter int TURN_CYCLES = 1,
    parameter int TIMEOUT     = 1023,
    parameter int CNT_W       = 10,
    parameter int P0_PRIORITY = 1
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [NREQ-1:0] req,
    input  logic            BUS_ready,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  owner,
    output logic            bus_busy,
    output logic            bus_err,
    output logic [IDW-1:0]  err_owner
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_TURN  = 2'd2;

    logic [1:0]      r_state;
    logic [NREQ-1:0] r_grant;
    logic [NREQ-1:0] r_lock;
    logic [IDW-1:0]  r_owner;
    logic [IDW-1:0]  r_rr;
    logic [IDW-1:0]  r_err_owner;
    logic            r_err;
    logic [CNT_W-1:0] r_wd;
    logic [3:0]      r_turn;

    logic [NREQ-1:0] w_elig;
    logic            w_found;
    logic [IDW-1:0]  w_win;
    logic [IDW-1:0]  w_idx;
    logic            w_release;
    logic            w_timeout;
    logic            w_arb;

    // Search starts just after the last winner and wraps modulo NREQ.
    always_comb begin
        w_elig  = req & ~r_lock;
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = r_rr;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
        if (P0_PRIORITY != 0 && w_elig[0]) begin
            w_found = 1'b1;
            w_win   = '0;
        end
    end

    assign w_release = !req[r_owner];
    assign w_timeout = (TIMEOUT != 0) && !BUS_ready && (r_wd == CNT_W'(TIMEOUT - 1));
    assign w_arb     = (r_state == S_IDLE) || (r_state == S_TURN && r_turn == 4'd0);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_lock      <= '0;
            r_owner     <= '0;
            r_rr        <= IDW'(NREQ - 1);
            r_err_owner <= '0;
            r_err       <= 1'b0;
            r_wd        <= '0;
            r_turn      <= '0;
        end else begin
            r_err  <= 1'b0;
            r_lock <= r_lock & req;
            if (w_arb) begin
                r_state <= w_found ? S_GRANT : S_IDLE;
                if (w_found) begin
                    r_grant <= NREQ'(1) << w_win;
                    r_owner <= w_win;
                    r_rr    <= w_win;
                    r_wd    <= '0;
                end
            end else if (r_state == S_TURN) begin
                r_turn <= r_turn - 1'b1;
            end else if (w_release || w_timeout) begin
                r_grant <= '0;
                r_state <= S_TURN;
                r_turn  <= 4'(TURN_CYCLES - 1);
                // A release in the timeout cycle wins: no error, no lockout.
                if (!w_release) begin
                    r_err       <= 1'b1;
                    r_err_owner <= r_owner;
                    r_lock      <= (r_lock & req) | (NREQ'(1) << r_owner);
                end
            end else begin
                r_wd <= BUS_ready ? '0 : r_wd + 1'b1;
            end
        end
    end

    assign grant     = r_grant;
    assign owner     = r_owner;
    assign bus_busy  = |r_grant;
    assign bus_err   = r_err;
    assign err_owner = r_err_owner;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: table vectors, hand sequences and a random run against a
// behavioural model for a 2-master priority arbiter and a 4-master round robin.
module tb_bus_arbiter;
    localparam int TMO  = 5;
    localparam int TURN = 1;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       rdy = 1'b1;
    logic [1:0] req_a = '0;
    logic [1:0] g_a;
    logic       o_a, busy_a, err_a, eo_a;
    logic [3:0] req_b = '0;
    logic [3:0] g_b;
    logic [1:0] o_b, eo_b;
    logic       busy_b, err_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] req;
        logic       rdy;
        logic [1:0] g;
        logic       e;
        logic       eo;
    } vec_t;
    vec_t tbl[$];

    int         m_own[2], m_last[2], m_gap[2], m_low[2], m_rr[2], m_eo[2];
    logic       m_err[2];
    logic [3:0] m_lock[2];

    bus_arbiter #(.NREQ(2), .IDW(1), .TURN_CYCLES(TURN), .TIMEOUT(TMO), .CNT_W(4), .P0_PRIORITY(1)) u_a (
        .clk(clk), .clr(clr), .req(req_a), .BUS_ready(rdy), .grant(g_a), .owner(o_a),
        .bus_busy(busy_a), .bus_err(err_a), .err_owner(eo_a));

    bus_arbiter #(.NREQ(4), .IDW(2), .TURN_CYCLES(TURN), .TIMEOUT(TMO), .CNT_W(4), .P0_PRIORITY(0)) u_b (
        .clk(clk), .clr(clr), .req(req_b), .BUS_ready(rdy), .grant(g_b), .owner(o_b),
        .bus_busy(busy_b), .bus_err(err_b), .err_owner(eo_b));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_own[k]  = -1;
            m_last[k] = 0;
            m_gap[k]  = 0;
            m_low[k]  = 0;
            m_rr[k]   = (k == 0) ? 1 : 3;
            m_eo[k]   = 0;
            m_err[k]  = 1'b0;
            m_lock[k] = '0;
        end
    endtask

    task automatic do_reset();
        clr = 1'b0;
        #2;
        clr = 1'b1;
        model_reset();
    endtask

    // Model: owner index or -1, remaining gap cycles, consecutive low-ready count.
    task automatic model_step(input int k, input logic [3:0] r, input logic rd);
        int         n    = (k == 0) ? 2 : 4;
        int         w    = -1;
        int         bd   = 99;
        logic [3:0] el   = r & ~m_lock[k];
        logic [3:0] setl = '0;
        m_err[k] = 1'b0;
        if (m_own[k] >= 0) begin
            if (!r[m_own[k]]) begin
                m_own[k] = -1;
                m_gap[k] = TURN;
            end else if (rd) begin
                m_low[k] = 0;
            end else begin
                m_low[k]++;
                if (m_low[k] == TMO) begin
                    m_err[k]        = 1'b1;
                    m_eo[k]         = m_own[k];
                    setl[m_own[k]]  = 1'b1;
                    m_own[k]        = -1;
                    m_gap[k]        = TURN;
                end
            end
        end else if (m_gap[k] > 1) begin
            m_gap[k]--;
        end else begin
            m_gap[k] = 0;
            if (k == 0 && el[0]) w = 0;
            else
                for (int i = 0; i < n; i++)
                    if (el[i] && ((i - m_rr[k] - 1 + n) % n) < bd) begin
                        w  = i;
                        bd = (i - m_rr[k] - 1 + n) % n;
                    end
            if (w >= 0) begin
                m_own[k]  = w;
                m_last[k] = w;
                m_rr[k]   = w;
                m_low[k]  = 0;
            end
        end
        m_lock[k] = (m_lock[k] & r) | setl;
    endtask

    function automatic logic [31:0] exp_pk(input int k);
        logic [3:0] g = (m_own[k] >= 0) ? 4'(1 << m_own[k]) : 4'b0;
        logic [31:0] l = m_last[k];
        logic [31:0] e = m_eo[k];
        if (k == 0) return {26'b0, g[1:0], l[0], |g, m_err[0], e[0]};
        return {22'b0, g, l[1:0], |g, m_err[1], e[1:0]};
    endfunction

    task automatic add(input logic [1:0] r, input logic rd, input logic [1:0] g,
                       input logic e, input logic eo, input int n);
        repeat (n) tbl.push_back(vec_t'{r, rd, g, e, eo});
    endtask

    initial begin
        // Handoff, watchdog revoke + lockout, ready toggling, release at timeout, no pre-emption, P0 priority.
        add(2'b11, 1, 2'b01, 0, 0, 5);
        add(2'b10, 1, 2'b00, 0, 0, 1);
        add(2'b10, 1, 2'b10, 0, 0, 2);
        add(2'b10, 0, 2'b10, 0, 0, 4);
        add(2'b10, 0, 2'b00, 1, 1, 1);
        add(2'b10, 1, 2'b00, 0, 1, 2);
        add(2'b00, 1, 2'b00, 0, 1, 1);
        add(2'b10, 1, 2'b10, 0, 1, 1);
        add(2'b10, 0, 2'b10, 0, 1, 4);
        add(2'b10, 1, 2'b10, 0, 1, 1);
        add(2'b10, 0, 2'b10, 0, 1, 4);
        add(2'b10, 1, 2'b10, 0, 1, 1);
        add(2'b10, 0, 2'b10, 0, 1, 4);
        add(2'b00, 0, 2'b00, 0, 1, 1);
        add(2'b00, 1, 2'b00, 0, 1, 1);
        add(2'b10, 1, 2'b10, 0, 1, 1);
        add(2'b11, 1, 2'b10, 0, 1, 2);
        add(2'b01, 1, 2'b00, 0, 1, 1);
        add(2'b01, 1, 2'b01, 0, 1, 1);
        add(2'b00, 1, 2'b00, 0, 1, 2);
        add(2'b11, 1, 2'b01, 0, 1, 1);
        add(2'b10, 1, 2'b00, 0, 1, 1);
        add(2'b10, 1, 2'b10, 0, 1, 1);

        #1 clr = 1'b0;
        #2;
        check("reset_a", {26'b0, g_a, o_a, busy_a, err_a, eo_a}, 32'h0);
        check("reset_b", {22'b0, g_b, o_b, busy_b, err_b, eo_b}, 32'h0);
        #1 clr = 1'b1;
        tick();

        foreach (tbl[i]) begin
            req_a = tbl[i].req;
            rdy   = tbl[i].rdy;
            tick();
            check($sformatf("tbl%0d_grant", i), 32'(g_a), 32'(tbl[i].g));
            check($sformatf("tbl%0d_err", i), 32'(err_a), 32'(tbl[i].e));
            check($sformatf("tbl%0d_err_owner", i), 32'(eo_a), 32'(tbl[i].eo));
        end

        rdy   = 1'b1;
        req_a = 2'b10;
        tick();
        check("pre_clr_grant", 32'(g_a), 32'h2);
        #2 clr = 1'b0;
        #1;
        check("async_clr_grant", 32'(g_a), 32'h0);
        check("async_clr_busy", 32'(busy_a), 32'h0);
        #1 clr = 1'b1;
        tick();
        check("post_clr_grant", 32'(g_a), 32'h2);

        do_reset();
        req_a = '0;
        req_b = 4'hf;
        tick();
        check("rr_first", 32'(g_b), 32'h1);
        for (int e = 0; e < 4; e++) begin
            repeat (2) begin
                tick();
                check($sformatf("rr_hold%0d", e), 32'(g_b), 32'(1 << e));
            end
            req_b[e] = 1'b0;
            tick();
            check($sformatf("rr_gap%0d", e), 32'(g_b), 32'h0);
            req_b = 4'hf;
            tick();
            check($sformatf("rr_next%0d", e), 32'(g_b), 32'(1 << ((e + 1) % 4)));
        end

        req_a = '0;
        req_b = '0;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < 2; i++) if ($urandom_range(0, 7) == 0) req_a[i] = ~req_a[i];
            for (int i = 0; i < 4; i++) if ($urandom_range(0, 7) == 0) req_b[i] = ~req_b[i];
            rdy = ($urandom_range(0, 9) < 4);
            model_step(0, {2'b00, req_a}, rdy);
            model_step(1, req_b, rdy);
            tick();
            check($sformatf("rand_a_c%0d", c), {26'b0, g_a, o_a, busy_a, err_a, eo_a}, exp_pk(0));
            check($sformatf("rand_b_c%0d", c), {22'b0, g_b, o_b, busy_b, err_b, eo_b}, exp_pk(1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
